// File: rtl/led_sw_arbiter.sv
// Board LED/switch arbiter: debounces switches toward the HPS and hands the LEDs
// between a local rotating pattern and the HPS, with dark guard intervals.
module led_sw_arbiter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_CYCLES     = 12500000,
  parameter int GUARD_CYCLES    = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_to_hps,
  input  logic [3:0] led_from_hps,
  input  logic       hps_req,
  output logic [3:0] led_out,
  output logic       hps_grant
);

  localparam int DB_EFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int TK_EFF = (TICK_CYCLES < 1) ? 1 : TICK_CYCLES;
  localparam int GD_EFF = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int DW = $clog2(DB_EFF + 1);
  localparam int TW = $clog2(TK_EFF + 1);
  localparam int GW = $clog2(GD_EFF + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_EFF - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TK_EFF - 1);
  localparam logic [GW-1:0] GD_LAST   = GW'(GD_EFF - 1);

  localparam logic [1:0] ST_LOCAL   = 2'd0;
  localparam logic [1:0] ST_GUARD_H = 2'd1;
  localparam logic [1:0] ST_HPS     = 2'd2;
  localparam logic [1:0] ST_GUARD_L = 2'd3;

  logic [3:0]         sw_meta;
  logic [3:0]         sw_sync;
  logic [3:0]         sw_stable;
  logic [3:0][DW-1:0] db_cnt;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [1:0]         state;
  logic [GW-1:0]      guard_cnt;
  logic               guard_done;
  logic [3:0]         pattern;
  logic               override;
  logic               grant_ok;
  logic [3:0]         led_nxt;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // A bit is accepted only after DB_EFF consecutive cycles of disagreement.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sw_stable <= '0;
      db_cnt    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw_sync[i] == sw_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_stable[i] <= sw_sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign sw_to_hps = sw_stable;
  assign override  = sw_stable[3];
  assign grant_ok  = hps_req & ~override;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign guard_done = (guard_cnt == GD_LAST);

  // Guards always run to completion; only HPS re-evaluates the request.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state     <= ST_LOCAL;
      guard_cnt <= '0;
    end else begin
      case (state)
        ST_LOCAL: begin
          if (grant_ok) begin
            state     <= ST_GUARD_H;
            guard_cnt <= '0;
          end
        end
        ST_GUARD_H: begin
          if (guard_done) begin
            state     <= ST_HPS;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        ST_HPS: begin
          if (!grant_ok) begin
            state     <= ST_GUARD_L;
            guard_cnt <= '0;
          end
        end
        ST_GUARD_L: begin
          if (guard_done) begin
            state     <= ST_LOCAL;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        default: begin
          state     <= ST_LOCAL;
          guard_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pattern <= 4'b0001;
    end else if (state == ST_LOCAL && tick) begin
      pattern <= {pattern[2:0], pattern[3]};
    end
  end

  always_comb begin
    led_nxt = 4'b0000;
    case (state)
      ST_LOCAL: led_nxt = pattern;
      ST_HPS:   led_nxt = led_from_hps;
      default:  led_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      led_out   <= 4'b0000;
      hps_grant <= 1'b0;
    end else begin
      led_out   <= led_nxt;
      hps_grant <= (state == ST_HPS);
    end
  end

endmodule
